wino_pad_io: RTL and testbench

- Parametrised pin-side I/O front end for the Winograd F(m,r) cores. It sits between the chip pad ring and the core.
- Input path: deserialises narrow pin beats into a full input tile, then hands it to the core over a valid/ready interface.
- Output path: serialises the core's result vector back onto narrow output pins.
- Successor to the fixed 10-in/10-out pad wrapper, generalised in pin width, word width and tile size. Adds framing, back-pressure absorption and sticky error status.

---
 rtl/wino_io_pkg.sv | 33 +++
 rtl/wino_out_ser.sv | 96 +++++++++
 rtl/wino_pad_io.sv | 127 ++++++++++++
 tb/tb_wino_pad_io.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wino_io_pkg.sv
// Shared types and elaboration helpers for the Winograd pad I/O front end.
// Beat/word derivation, FSM state types and counter sizing live here.
package wino_io_pkg;

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    FILL = 1'b1
  } asm_state_e;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_e;

  function automatic int beats_of(input int data_w, input int pin_w);
    return data_w / pin_w;
  endfunction

  function automatic bit width_ok(input int data_w, input int pin_w);
    return (pin_w > 0) && ((data_w % pin_w) == 0);
  endfunction

  // Width needed to hold 0..n-1; never narrower than one bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/wino_out_ser.sv
// Result serialiser: captures one core result and streams it onto the output
// pins, sample 0 first and least-significant slice first within each word.
module wino_out_ser
  import wino_io_pkg::*;
#(
  parameter int PIN_W  = 10,
  parameter int DATA_W = 10,
  parameter int N_OUT  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_OUT*DATA_W-1:0] res_data,
  input  logic                    res_vld,
  output logic                    res_rdy,
  output logic [PIN_W-1:0]        dout,
  output logic                    dout_vld
);

  localparam int BEATS = beats_of(DATA_W, PIN_W);
  localparam int NB    = N_OUT * BEATS;
  localparam int CW    = clog2(NB);
  localparam int RW    = N_OUT * DATA_W;
  localparam logic [CW-1:0] LAST = CW'(NB - 1);

  ser_state_e          r_state;
  logic [CW-1:0]       r_cnt;
  logic [RW-1:0]       r_shift;
  logic [PIN_W-1:0]    r_dout;
  logic                r_dout_vld;
  logic                r_res_rdy;

  ser_state_e          w_state_nx;
  logic [CW-1:0]       w_cnt_nx;
  logic [RW-1:0]       w_shift_nx;
  logic [PIN_W-1:0]    w_dout_nx;
  logic                w_vld_nx;
  logic                w_rdy_nx;
  logic                w_acc;
  logic                w_last;

  assign w_acc  = res_vld & r_res_rdy;
  assign w_last = (r_state == SEND) && (r_cnt == LAST);

  // A new result can be taken in IDLE or on the final beat, so back-to-back
  // results stream with no bubble; res_rdy is precomputed for the next cycle.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_shift_nx = r_shift;
    w_dout_nx  = r_dout;
    w_vld_nx   = r_dout_vld;
    if (w_acc) begin
      w_state_nx = SEND;
      w_cnt_nx   = '0;
      w_dout_nx  = res_data[PIN_W-1:0];
      w_shift_nx = res_data >> PIN_W;
      w_vld_nx   = 1'b1;
    end else if (r_state == SEND) begin
      if (w_last) begin
        w_state_nx = IDLE;
        w_vld_nx   = 1'b0;
      end else begin
        w_cnt_nx   = r_cnt + CW'(1);
        w_dout_nx  = r_shift[PIN_W-1:0];
        w_shift_nx = r_shift >> PIN_W;
        w_vld_nx   = 1'b1;
      end
    end else begin
      w_vld_nx = 1'b0;
    end
    w_rdy_nx = (w_state_nx == IDLE) || (w_cnt_nx == LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_dout     <= '0;
      r_dout_vld <= 1'b0;
      r_res_rdy  <= 1'b1;
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_shift    <= w_shift_nx;
      r_dout     <= w_dout_nx;
      r_dout_vld <= w_vld_nx;
      r_res_rdy  <= w_rdy_nx;
    end
  end

  assign res_rdy  = r_res_rdy;
  assign dout     = r_dout;
  assign dout_vld = r_dout_vld;

endmodule

// File: rtl/wino_pad_io.sv
// Pin-side I/O front end: assembles narrow input beats into tiles for the core
// and serialises core results back to the pins, with sticky framing/drop flags.
module wino_pad_io
  import wino_io_pkg::*;
#(
  parameter int PIN_W  = 10,
  parameter int DATA_W = 10,
  parameter int N_IN   = 4,
  parameter int N_OUT  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PIN_W-1:0]        din,
  input  logic                    din_vld,
  input  logic                    din_sof,
  output logic [N_IN*DATA_W-1:0]  tile_data,
  output logic                    tile_vld,
  input  logic                    tile_rdy,
  input  logic [N_OUT*DATA_W-1:0] res_data,
  input  logic                    res_vld,
  output logic                    res_rdy,
  output logic [PIN_W-1:0]        dout,
  output logic                    dout_vld,
  input  logic                    err_clr,
  output logic                    ovf_err,
  output logic                    sof_err
);

  localparam int BEATS = beats_of(DATA_W, PIN_W);
  localparam int NBI   = N_IN * BEATS;
  localparam int IW    = clog2(NBI);
  localparam int TW    = N_IN * DATA_W;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBI - 1);

  if (!width_ok(DATA_W, PIN_W)) begin : g_bad_width
    $error("wino_pad_io: DATA_W must be an integer multiple of PIN_W");
  end

  asm_state_e       r_state;
  logic [IW-1:0]    r_idx;
  logic [TW-1:0]    r_buf;
  logic [TW-1:0]    r_tile_data;
  logic             r_tile_vld;
  logic             r_ovf_err;
  logic             r_sof_err;

  logic             w_beat;
  logic             w_sof_viol;
  logic [IW-1:0]    w_wr_idx;
  logic             w_last;
  logic             w_hold_free;
  logic             w_ovf_set;
  logic [TW-1:0]    w_tile;

  assign w_beat      = din_vld & ((r_state == FILL) | din_sof);
  assign w_sof_viol  = din_vld & din_sof & (r_state == FILL) & (r_idx != '0);
  assign w_wr_idx    = w_sof_viol ? '0 : r_idx;
  assign w_last      = w_beat & (w_wr_idx == LAST_IDX);
  assign w_hold_free = ~r_tile_vld | tile_rdy;
  assign w_ovf_set   = w_last & ~w_hold_free;

  // Beat k of a tile lands at bit k*PIN_W, giving sample-0/LS-slice-first order.
  always_comb begin
    w_tile = r_buf;
    w_tile[w_wr_idx*PIN_W +: PIN_W] = din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= HUNT;
      r_idx   <= '0;
      r_buf   <= '0;
    end else if (w_beat) begin
      r_buf <= w_tile;
      if (w_last) begin
        r_state <= HUNT;
        r_idx   <= '0;
      end else begin
        r_state <= FILL;
        r_idx   <= w_wr_idx + IW'(1);
      end
    end
  end

  // A completed tile is dropped rather than overwriting an unconsumed one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tile_data <= '0;
      r_tile_vld  <= 1'b0;
    end else if (w_last && w_hold_free) begin
      r_tile_data <= w_tile;
      r_tile_vld  <= 1'b1;
    end else if (tile_rdy) begin
      r_tile_vld  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf_err <= 1'b0;
      r_sof_err <= 1'b0;
    end else begin
      r_ovf_err <= w_ovf_set | (r_ovf_err & ~err_clr);
      r_sof_err <= w_sof_viol | (r_sof_err & ~err_clr);
    end
  end

  wino_out_ser #(
    .PIN_W  (PIN_W),
    .DATA_W (DATA_W),
    .N_OUT  (N_OUT)
  ) u_out_ser (
    .clk      (clk),
    .rst      (rst),
    .res_data (res_data),
    .res_vld  (res_vld),
    .res_rdy  (res_rdy),
    .dout     (dout),
    .dout_vld (dout_vld)
  );

  assign tile_data = r_tile_data;
  assign tile_vld  = r_tile_vld;
  assign ovf_err   = r_ovf_err;
  assign sof_err   = r_sof_err;

endmodule

// File: tb/tb_wino_pad_io.sv
// Scoreboard bench for wino_pad_io with default parameters: expected tiles and
// output beats are queued as stimulus is driven and checked as the DUT emits them.
module tb_wino_pad_io;

  logic        clk;
  logic        rst;
  logic [9:0]  din;
  logic        din_vld;
  logic        din_sof;
  logic [39:0] tile_data;
  logic        tile_vld;
  logic        tile_rdy;
  logic [19:0] res_data;
  logic        res_vld;
  logic        res_rdy;
  logic [9:0]  dout;
  logic        dout_vld;
  logic        err_clr;
  logic        ovf_err;
  logic        sof_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [39:0] exp_tiles[$];
  logic [9:0]  exp_beats[$];
  logic [39:0] exp_t;
  logic [9:0]  exp_b;

  wino_pad_io #(.PIN_W(10), .DATA_W(10), .N_IN(4), .N_OUT(2)) dut (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .din_sof(din_sof),
    .tile_data(tile_data), .tile_vld(tile_vld), .tile_rdy(tile_rdy),
    .res_data(res_data), .res_vld(res_vld), .res_rdy(res_rdy),
    .dout(dout), .dout_vld(dout_vld), .err_clr(err_clr),
    .ovf_err(ovf_err), .sof_err(sof_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every tile handshake and every output beat is popped and compared.
  always @(negedge clk) begin
    if (!rst && tile_vld && tile_rdy) begin
      n_tests++;
      if (exp_tiles.size() == 0) begin
        n_fail++;
        $display("FAIL tile_unexpected got=%h", tile_data);
      end else begin
        exp_t = exp_tiles.pop_front();
        if (tile_data !== exp_t) begin
          n_fail++;
          $display("FAIL tile_data got=%h exp=%h", tile_data, exp_t);
        end
      end
    end
    if (!rst && dout_vld) begin
      n_tests++;
      if (exp_beats.size() == 0) begin
        n_fail++;
        $display("FAIL dout_unexpected got=%h", dout);
      end else begin
        exp_b = exp_beats.pop_front();
        if (dout !== exp_b) begin
          n_fail++;
          $display("FAIL dout got=%h exp=%h", dout, exp_b);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [9:0] v, input logic sof, input int gap);
    din     = v;
    din_vld = 1'b1;
    din_sof = sof;
    tick();
    din_vld = 1'b0;
    din_sof = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    n_tests += 7;
    if (tile_vld !== 1'b0)   begin n_fail++; $display("FAIL rst_tile_vld got=%b exp=0", tile_vld); end
    if (tile_data !== 40'h0) begin n_fail++; $display("FAIL rst_tile_data got=%h exp=0", tile_data); end
    if (res_rdy !== 1'b1)    begin n_fail++; $display("FAIL rst_res_rdy got=%b exp=1", res_rdy); end
    if (dout !== 10'h0)      begin n_fail++; $display("FAIL rst_dout got=%h exp=0", dout); end
    if (dout_vld !== 1'b0)   begin n_fail++; $display("FAIL rst_dout_vld got=%b exp=0", dout_vld); end
    if (ovf_err !== 1'b0)    begin n_fail++; $display("FAIL rst_ovf_err got=%b exp=0", ovf_err); end
    if (sof_err !== 1'b0)    begin n_fail++; $display("FAIL rst_sof_err got=%b exp=0", sof_err); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    tile_rdy = 1'b1;
    exp_tiles.push_back({10'h004, 10'h003, 10'h002, 10'h001});
    send_beat(10'h001, 1'b1, 0);
    send_beat(10'h002, 1'b0, 0);
    send_beat(10'h003, 1'b0, 0);
    n_tests++;
    if (tile_vld !== 1'b0) begin n_fail++; $display("FAIL basic_early got=%b exp=0", tile_vld); end
    send_beat(10'h004, 1'b0, 0);
    n_tests += 2;
    if (tile_vld !== 1'b1) begin n_fail++; $display("FAIL basic_latency got=%b exp=1", tile_vld); end
    if (ovf_err !== 1'b0)  begin n_fail++; $display("FAIL basic_ovf got=%b exp=0", ovf_err); end
    tick();
    n_tests++;
    if (tile_vld !== 1'b0) begin n_fail++; $display("FAIL basic_consumed got=%b exp=0", tile_vld); end
  endtask

  task automatic test_gapped();
    tile_rdy = 1'b1;
    exp_tiles.push_back({10'h004, 10'h003, 10'h002, 10'h001});
    send_beat(10'h001, 1'b1, 2);
    send_beat(10'h002, 1'b0, 2);
    send_beat(10'h003, 1'b0, 2);
    n_tests++;
    if (tile_vld !== 1'b0) begin n_fail++; $display("FAIL gap_early got=%b exp=0", tile_vld); end
    send_beat(10'h004, 1'b0, 0);
    n_tests++;
    if (tile_vld !== 1'b1) begin n_fail++; $display("FAIL gap_latency got=%b exp=1", tile_vld); end
    tick();
  endtask

  task automatic test_resync();
    tile_rdy = 1'b1;
    exp_tiles.push_back({10'h044, 10'h033, 10'h022, 10'h011});
    send_beat(10'h0AA, 1'b1, 0);
    send_beat(10'h0BB, 1'b0, 0);
    send_beat(10'h011, 1'b1, 0);
    send_beat(10'h022, 1'b0, 0);
    send_beat(10'h033, 1'b0, 0);
    send_beat(10'h044, 1'b0, 0);
    n_tests += 2;
    if (sof_err !== 1'b1) begin n_fail++; $display("FAIL resync_sof_err got=%b exp=1", sof_err); end
    if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL resync_ovf got=%b exp=0", ovf_err); end
    tick();
    // Violation coinciding with err_clr must leave the flag set.
    send_beat(10'h0AA, 1'b1, 0);
    err_clr = 1'b1;
    send_beat(10'h0CC, 1'b1, 0);
    err_clr = 1'b0;
    n_tests++;
    if (sof_err !== 1'b1) begin n_fail++; $display("FAIL resync_err_wins got=%b exp=1", sof_err); end
    exp_tiles.push_back({10'h0FF, 10'h0EE, 10'h0DD, 10'h0CC});
    send_beat(10'h0DD, 1'b0, 0);
    send_beat(10'h0EE, 1'b0, 0);
    send_beat(10'h0FF, 1'b0, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_tests++;
    if (sof_err !== 1'b0) begin n_fail++; $display("FAIL resync_clr got=%b exp=0", sof_err); end
  endtask

  task automatic test_overflow();
    tile_rdy = 1'b0;
    exp_tiles.push_back({10'h1A4, 10'h1A3, 10'h1A2, 10'h1A1});
    send_beat(10'h1A1, 1'b1, 0);
    send_beat(10'h1A2, 1'b0, 0);
    send_beat(10'h1A3, 1'b0, 0);
    send_beat(10'h1A4, 1'b0, 0);
    send_beat(10'h2B1, 1'b1, 0);
    send_beat(10'h2B2, 1'b0, 0);
    send_beat(10'h2B3, 1'b0, 0);
    send_beat(10'h2B4, 1'b0, 0);
    n_tests += 3;
    if (ovf_err !== 1'b1)  begin n_fail++; $display("FAIL ovf_set got=%b exp=1", ovf_err); end
    if (tile_vld !== 1'b1) begin n_fail++; $display("FAIL ovf_held_vld got=%b exp=1", tile_vld); end
    if (tile_data !== {10'h1A4, 10'h1A3, 10'h1A2, 10'h1A1}) begin
      n_fail++; $display("FAIL ovf_held_data got=%h exp=%h", tile_data, {10'h1A4, 10'h1A3, 10'h1A2, 10'h1A1});
    end
    tile_rdy = 1'b1;
    tick();
    tick();
    n_tests++;
    if (tile_vld !== 1'b0) begin n_fail++; $display("FAIL ovf_drained got=%b exp=0", tile_vld); end
    err_clr = 1'b1;
    n_tests++;
    if (ovf_err !== 1'b1) begin n_fail++; $display("FAIL ovf_before_clr got=%b exp=1", ovf_err); end
    tick();
    err_clr = 1'b0;
    n_tests++;
    if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL ovf_clr got=%b exp=0", ovf_err); end
  endtask

  task automatic test_back_to_back();
    exp_beats.push_back(10'h155);
    exp_beats.push_back(10'h3FF);
    exp_beats.push_back(10'h00F);
    exp_beats.push_back(10'h0F0);
    res_data = {10'h3FF, 10'h155};
    res_vld  = 1'b1;
    tick();
    res_data = {10'h0F0, 10'h00F};
    n_tests += 2;
    if (dout_vld !== 1'b1) begin n_fail++; $display("FAIL ser_first_vld got=%b exp=1", dout_vld); end
    if (res_rdy !== 1'b0)  begin n_fail++; $display("FAIL ser_busy_rdy got=%b exp=0", res_rdy); end
    tick();
    n_tests++;
    if (res_rdy !== 1'b1)  begin n_fail++; $display("FAIL ser_last_rdy got=%b exp=1", res_rdy); end
    tick();
    res_vld = 1'b0;
    n_tests++;
    if (dout_vld !== 1'b1) begin n_fail++; $display("FAIL ser_no_bubble got=%b exp=1", dout_vld); end
    tick();
    tick();
    n_tests += 3;
    if (dout_vld !== 1'b0) begin n_fail++; $display("FAIL ser_idle_vld got=%b exp=0", dout_vld); end
    if (dout !== 10'h0F0)  begin n_fail++; $display("FAIL ser_hold got=%h exp=0f0", dout); end
    if (res_rdy !== 1'b1)  begin n_fail++; $display("FAIL ser_idle_rdy got=%b exp=1", res_rdy); end
  endtask

  task automatic test_reset_mid();
    tile_rdy = 1'b1;
    send_beat(10'h0C1, 1'b1, 0);
    send_beat(10'h0C2, 1'b0, 0);
    rst = 1'b1;
    #3;
    n_tests++;
    if (tile_vld !== 1'b0) begin n_fail++; $display("FAIL mid_rst_vld got=%b exp=0", tile_vld); end
    tick();
    rst = 1'b0;
    tick();
    exp_tiles.push_back({10'h0D4, 10'h0D3, 10'h0D2, 10'h0D1});
    send_beat(10'h0D1, 1'b1, 0);
    send_beat(10'h0D2, 1'b0, 0);
    send_beat(10'h0D3, 1'b0, 0);
    send_beat(10'h0D4, 1'b0, 0);
    n_tests += 3;
    if (tile_vld !== 1'b1) begin n_fail++; $display("FAIL mid_clean_vld got=%b exp=1", tile_vld); end
    if (sof_err !== 1'b0)  begin n_fail++; $display("FAIL mid_sof_err got=%b exp=0", sof_err); end
    if (ovf_err !== 1'b0)  begin n_fail++; $display("FAIL mid_ovf_err got=%b exp=0", ovf_err); end
    tick();
  endtask

  initial begin
    rst      = 1'b1;
    din      = 10'h0;
    din_vld  = 1'b0;
    din_sof  = 1'b0;
    tile_rdy = 1'b0;
    res_data = 20'h0;
    res_vld  = 1'b0;
    err_clr  = 1'b0;
    test_reset();
    test_basic();
    test_gapped();
    test_resync();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    repeat (4) tick();
    n_tests += 2;
    if (exp_tiles.size() != 0) begin n_fail++; $display("FAIL tiles_pending got=%0d exp=0", exp_tiles.size()); end
    if (exp_beats.size() != 0) begin n_fail++; $display("FAIL beats_pending got=%0d exp=0", exp_beats.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
